// File: rtl/wb_stream_loader_if.sv
// Stream-side and Wishbone-side signals of the image loader, bundled for port hookup.
// Stream: a byte transfers on a rising clk when s_valid_i & s_ready_o; Wishbone: a write is issued when stb & !stall.
interface wb_stream_loader_if #(
  parameter int ADDR_WIDTH = 14
) ();
  logic [7:0]            s_data_i;
  logic                  s_valid_i;
  logic                  s_last_i;
  logic                  s_ready_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [31:0]           wb_dat_o;
  logic [3:0]            wb_sel_o;
  logic                  wb_we_o;
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_stall_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;

  modport master (
    input  s_data_i, s_valid_i, s_last_i, wb_stall_i, wb_ack_i, wb_err_i,
    output s_ready_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );

  modport slave (
    output s_data_i, s_valid_i, s_last_i, wb_stall_i, wb_ack_i, wb_err_i,
    input  s_ready_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
  );
endinterface

// File: rtl/wb_stream_loader.sv
// Packs a byte stream little-endian into 32-bit words and writes them with single
// pipelined Wishbone writes at consecutive word addresses starting from a programmed base.
module wb_stream_loader #(
  parameter int ADDR_WIDTH = 14,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_adr_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH:0]   words_o,
  output logic [1:0]            dbg_state_o,
  wb_stream_loader_if.master    bus
);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    WRITE    = 2'd2,
    WAIT_ACK = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;
  logic [1:0]            idx_q, idx_d;
  logic                  last_q, last_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    last_d  = last_q;
    error_d = error_q;
    words_d = words_q;
    tmo_d   = tmo_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // busy_q is still high during the done cycle, so a start there is ignored
        if (start_i && !busy_q) begin
          state_d = COLLECT;
          adr_d   = base_adr_i;
          words_d = '0;
          error_d = 1'b0;
          idx_d   = 2'd0;
          dat_d   = '0;
          sel_d   = '0;
          last_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (bus.s_valid_i) begin
          dat_d[{idx_q, 3'b000} +: 8] = bus.s_data_i;
          sel_d[idx_q]                = 1'b1;
          idx_d                       = idx_q + 2'd1;
          if (idx_q == 2'd3 || bus.s_last_i) begin
            state_d = WRITE;
            last_d  = bus.s_last_i;
            tmo_d   = '0;
          end
        end
      end
      WRITE, WAIT_ACK: begin
        // err outranks a simultaneous ack; the failed word is not counted
        if (bus.wb_err_i || (!bus.wb_ack_i && tmo_q == TMO_LAST)) begin
          state_d = IDLE;
          error_d = 1'b1;
          done_d  = 1'b1;
          idx_d   = 2'd0;
          dat_d   = '0;
          sel_d   = '0;
        end else if (bus.wb_ack_i) begin
          words_d = words_q + 1'b1;
          adr_d   = adr_q + 1'b1;
          idx_d   = 2'd0;
          dat_d   = '0;
          sel_d   = '0;
          if (last_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (state_q == WRITE && !bus.wb_stall_i) state_d = WAIT_ACK;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      words_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      words_q <= words_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.s_ready_o = (state_q == COLLECT);
  assign bus.wb_cyc_o  = (state_q == WRITE) || (state_q == WAIT_ACK);
  assign bus.wb_we_o   = (state_q == WRITE) || (state_q == WAIT_ACK);
  assign bus.wb_stb_o  = (state_q == WRITE);
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_sel_o  = sel_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;
  assign words_o       = words_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_wb_stream_loader.sv
// Bench for wb_stream_loader: vector table, hand-written corner sequences and random loads
// checked against a word-level model of the image that should land in memory.
module tb_wb_stream_loader;
  localparam int AW  = 14;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] base_adr_i = '0;
  logic          busy_o, done_o, error_o;
  logic [AW:0]   words_o;
  logic [1:0]    dbg_state;

  wb_stream_loader_if #(.ADDR_WIDTH(AW)) bus ();

  wb_stream_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_adr_i(base_adr_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .words_o(words_o),
    .dbg_state_o(dbg_state), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    logic [7:0]    b0;
    logic [7:0]    stp;
    int            err_word;
    bit            both;
    bit            noack;
    int            stall;
    bit            classic;
    bit            mid_start;
    int            exp_words;
    bit            exp_error;
  } vec_t;

  // slave configuration, written only by the main process
  int cfg_stall = 0;
  bit cfg_classic = 1'b0;
  bit cfg_noack = 1'b0;
  int cfg_err_word = -1;
  bit cfg_both = 1'b0;

  // slave / monitor state, written only by the monitor process
  int            done_cnt = 0, cyc_len = 0, last_cyc_len = 0, stb_len = 0, last_stb_len = 0;
  int            ready_lat = -1, ack_cyc = 0, cyc_no = 0, wr_idx = 0, scnt = 0, stab_bad = 0, got_n = 0;
  bit            armed = 1'b0, pend = 1'b0, prev_stb = 1'b0, busy_prev = 1'b0;
  logic [AW-1:0] prev_adr = '0, acc_adr = '0;
  logic [31:0]   prev_dat = '0, acc_dat = '0;
  logic [3:0]    prev_sel = '0, acc_sel = '0;
  logic [AW-1:0] got_adr [1024];
  logic [31:0]   got_dat [1024];
  logic [3:0]    got_sel [1024];

  // main-process state
  int            check_cnt = 0, pass_cnt = 0, rd_n = 0;
  logic [AW+35:0] exp_q[$];
  logic [7:0]    stream_b [64];
  vec_t          tbl [10];

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      scnt = 0;
      armed = 1'b0;
      bus.wb_stall_i = 1'b0;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
    end else begin
      if (busy_o && !busy_prev) begin
        wr_idx = 0;
        ready_lat = -1;
        armed = 1'b0;
      end
      if (armed && bus.s_ready_o) begin
        ready_lat = cyc_no - ack_cyc;
        armed = 1'b0;
      end
      if (done_o) begin
        done_cnt++;
        armed = 1'b0;
      end
      if (bus.wb_cyc_o) cyc_len++;
      else if (cyc_len > 0) begin last_cyc_len = cyc_len; cyc_len = 0; end
      if (bus.wb_stb_o) stb_len++;
      else if (stb_len > 0) begin last_stb_len = stb_len; stb_len = 0; end
      if (bus.wb_stb_o && prev_stb &&
          (bus.wb_adr_o != prev_adr || bus.wb_dat_o != prev_dat || bus.wb_sel_o != prev_sel))
        stab_bad++;
      if (bus.wb_we_o !== bus.wb_cyc_o) stab_bad++;
      prev_stb = bus.wb_stb_o;
      prev_adr = bus.wb_adr_o;
      prev_dat = bus.wb_dat_o;
      prev_sel = bus.wb_sel_o;

      bus.wb_stall_i = 1'b0;
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (!bus.wb_cyc_o) begin
        pend = 1'b0;
        scnt = 0;
      end else if (bus.wb_stb_o || pend) begin
        if (bus.wb_stb_o && scnt < cfg_stall) begin
          bus.wb_stall_i = 1'b1;
          scnt++;
        end else begin
          if (bus.wb_stb_o) begin
            acc_adr = bus.wb_adr_o;
            acc_dat = bus.wb_dat_o;
            acc_sel = bus.wb_sel_o;
          end
          if (bus.wb_stb_o && !cfg_classic) pend = 1'b1;
          else begin
            pend = 1'b0;
            scnt = 0;
            if (!cfg_noack) begin
              if (wr_idx == cfg_err_word) begin
                bus.wb_err_i = 1'b1;
                bus.wb_ack_i = cfg_both;
              end else begin
                bus.wb_ack_i = 1'b1;
                got_adr[got_n] = acc_adr;
                got_dat[got_n] = acc_dat;
                got_sel[got_n] = acc_sel;
                got_n++;
                ack_cyc = cyc_no;
                armed = 1'b1;
              end
              wr_idx++;
            end
          end
        end
      end
    end
    busy_prev = busy_o;
    cyc_no++;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic fail_now(input string name);
    check_cnt++;
    $display("FAIL %s: event did not occur within its cycle budget", name);
  endtask

  // Outcome of a load from the image rules: ceil(n/4) words, cut short by the first failing word.
  function automatic void model_outcome(input int n, input int err_word, input bit noack,
                                        output int words, output bit error);
    int nw;
    nw = (n + 3) / 4;
    if (noack) begin
      words = 0; error = 1'b1;
    end else if (err_word >= 0 && err_word < nw) begin
      words = err_word; error = 1'b1;
    end else begin
      words = nw; error = 1'b0;
    end
  endfunction

  task automatic model_writes(input logic [AW-1:0] base, input int n, input int nwrites);
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic [3:0]    s;
    for (int w = 0; w < nwrites; w++) begin
      d = '0;
      s = '0;
      for (int k = 0; k < 4; k++) begin
        if (4 * w + k < n) begin
          d = d | (32'(stream_b[4 * w + k]) << (8 * k));
          s = s | 4'(1 << k);
        end
      end
      a = base + AW'(w);
      exp_q.push_back({a, d, s});
    end
  endtask

  task automatic check_writes();
    logic [AW+35:0] e;
    while (rd_n < got_n) begin
      if (exp_q.size() == 0) begin
        check_cnt++;
        $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, expected no write", got_adr[rd_n], got_dat[rd_n]);
      end else begin
        e = exp_q.pop_front();
        chk("wr_adr", 64'(got_adr[rd_n]), 64'(e[AW+35:36]));
        chk("wr_dat", 64'(got_dat[rd_n]), 64'(e[35:4]));
        chk("wr_sel", 64'(got_sel[rd_n]), 64'(e[3:0]));
      end
      rd_n++;
    end
    chk("writes_missing", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic drive_bytes(input int n, input bit gaps, input bit mid_start,
                             input logic [AW-1:0] base, input int d0);
    int  i, guard;
    bit  ms;
    i = 0; guard = 0; ms = 1'b0;
    while (i < n && done_cnt == d0 && guard < 400) begin
      start_i = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.s_valid_i = 1'b0;
      end else begin
        bus.s_valid_i = 1'b1;
        bus.s_data_i = stream_b[i];
        bus.s_last_i = (i == n - 1);
        if (mid_start && i == 2 && !ms) begin
          start_i = 1'b1;
          base_adr_i = ~base;
          ms = 1'b1;
        end
        if (bus.s_ready_o) i++;
      end
      step();
      guard++;
    end
    bus.s_valid_i = 1'b0;
    bus.s_last_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic run_load(input vec_t v, input bit gaps);
    int words, d0, guard;
    bit error;
    model_outcome(v.n, v.err_word, v.noack, words, error);
    model_writes(v.base, v.n, words);
    cfg_stall = v.stall;
    cfg_classic = v.classic;
    cfg_noack = v.noack;
    cfg_err_word = v.err_word;
    cfg_both = v.both;
    d0 = done_cnt;
    start_i = 1'b1;
    base_adr_i = v.base;
    step();
    start_i = 1'b0;
    base_adr_i = AW'($urandom);
    chk("start_busy", 64'(busy_o), 64'd1);
    chk("start_ready", 64'(bus.s_ready_o), 64'd1);
    chk("start_err_clear", 64'(error_o), 64'd0);
    drive_bytes(v.n, gaps, v.mid_start, v.base, d0);
    guard = 0;
    while (done_cnt == d0 && guard < 300) begin
      step();
      guard++;
    end
    if (done_cnt == d0) begin
      fail_now("done_wait");
    end else begin
      chk("done_words", 64'(words_o), 64'(v.exp_words));
      chk("done_error", 64'(error_o), 64'(v.exp_error));
      chk("done_busy_high", 64'(busy_o), 64'd1);
      chk("done_cyc_low", 64'(bus.wb_cyc_o), 64'd0);
      chk("done_ready_low", 64'(bus.s_ready_o), 64'd0);
      if (v.noack) chk("timeout_cyc_len", 64'(last_cyc_len), 64'(TMO));
      check_writes();
      step();
      chk("busy_after_done", 64'(busy_o), 64'd0);
      chk("done_single", 64'(done_cnt - d0), 64'd1);
      chk("idle_state", 64'(dbg_state), 64'd0);
    end
  endtask

  task automatic fill_pattern(input vec_t v);
    for (int i = 0; i < 64; i++) stream_b[i] = v.b0 + 8'(i) * v.stp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   d0, w;
    bit   e;

    bus.s_valid_i = 1'b0;
    bus.s_last_i = 1'b0;
    bus.s_data_i = '0;
    tbl[0] = '{14'h0010,  8, 8'h11, 8'h11, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2, 1'b0};
    tbl[1] = '{14'h0020,  5, 8'h01, 8'h01, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2, 1'b0};
    tbl[2] = '{14'h3FFF,  8, 8'hA0, 8'h03, -1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 2, 1'b0};
    tbl[3] = '{14'h0100, 12, 8'h5A, 8'h07,  1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1'b1};
    tbl[4] = '{14'h0200,  4, 8'hC3, 8'h01, -1, 1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b1};
    tbl[5] = '{14'h0201,  3, 8'h10, 8'h10, -1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1, 1'b0};
    tbl[6] = '{14'h0300,  1, 8'hEE, 8'h00, -1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 1'b0};
    tbl[7] = '{14'h0040,  6, 8'h80, 8'h05, -1, 1'b0, 1'b0, 2, 1'b0, 1'b1, 2, 1'b0};
    tbl[8] = '{14'h0050,  4, 8'h33, 8'h11,  0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b1};
    tbl[9] = '{14'h0060,  7, 8'h09, 8'h09,  2, 1'b0, 1'b0, 1, 1'b1, 1'b0, 2, 1'b0};

    repeat (3) step();
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_words", 64'(words_o), 64'd0);
    chk("rst_ready", 64'(bus.s_ready_o), 64'd0);
    chk("rst_bus_ctl", 64'({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}), 64'd0);
    chk("rst_bus_data", 64'({bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 10; t++) begin
      fill_pattern(tbl[t]);
      run_load(tbl[t], 1'b0);
    end

    // classic slave: stall three cycles, then drop stall together with ack
    v = '{14'h0070, 8, 8'h21, 8'h01, -1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 2, 1'b0};
    fill_pattern(v);
    run_load(v, 1'b0);
    chk("stall_stb_len", 64'(last_stb_len), 64'd4);
    chk("stall_ready_lat", 64'(ready_lat), 64'd1);
    chk("stb_stable", 64'(stab_bad), 64'd0);

    // reset in the middle of a stalled write
    v = '{14'h00AB, 4, 8'h42, 8'h01, -1, 1'b0, 1'b0, 100, 1'b0, 1'b0, 0, 1'b0};
    fill_pattern(v);
    cfg_stall = 100; cfg_classic = 1'b0; cfg_noack = 1'b0; cfg_err_word = -1; cfg_both = 1'b0;
    d0 = done_cnt;
    start_i = 1'b1;
    base_adr_i = v.base;
    step();
    start_i = 1'b0;
    drive_bytes(4, 1'b0, 1'b0, v.base, d0);
    chk("pre_reset_stb", 64'(bus.wb_stb_o), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_reset_cyc_stb", 64'({bus.wb_cyc_o, bus.wb_stb_o}), 64'd0);
    chk("mid_reset_busy", 64'(busy_o), 64'd0);
    chk("mid_reset_words", 64'(words_o), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    chk("post_reset_state", 64'(dbg_state), 64'd0);
    fill_pattern(tbl[0]);
    run_load(tbl[0], 1'b0);

    for (int r = 0; r < 30; r++) begin
      v.base = AW'($urandom);
      v.n = $urandom_range(1, 13);
      v.err_word = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      v.both = 1'(($urandom_range(0, 1)));
      v.noack = ($urandom_range(0, 9) == 0);
      v.stall = $urandom_range(0, 3);
      v.classic = 1'(($urandom_range(0, 1)));
      v.mid_start = 1'(($urandom_range(0, 1)));
      v.b0 = '0;
      v.stp = '0;
      for (int i = 0; i < 64; i++) stream_b[i] = 8'($urandom);
      model_outcome(v.n, v.err_word, v.noack, w, e);
      v.exp_words = w;
      v.exp_error = e;
      run_load(v, 1'b1);
    end
    chk("stb_stable_all", 64'(stab_bad), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/wb_stream_loader.md
# wb_stream_loader

Byte-stream-to-Wishbone write engine that sits directly upstream of a port of the dual-port Wishbone RAM (`wb_dp_ram_wrapper`). It packs an incoming byte stream little-endian into 32-bit words and issues single pipelined Wishbone writes at consecutive word addresses from a programmed base. It is used to load memory images at run time, for example from a UART or SPI-flash reader.

## Interface
Parameters:
- `ADDR_WIDTH`, default 14: word-address width; matches the RAM.
- `TIMEOUT`, default 255: maximum cycles to wait for ack per write before aborting. Must be ≥1.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, asynchronous, active-low
- `start_i`  in  1  one-cycle pulse; begins a load; ignored while `busy_o`=1
- `base_adr_i`  in  ADDR_WIDTH  first word address; sampled on an accepted `start_i`
- `busy_o`  out  1  high from the cycle after start until the cycle after done
- `done_o`  out  1  one-cycle pulse at end of load (normal or aborted)
- `error_o`  out  1  sticky abort flag; cleared on the next accepted start
- `words_o`  out  ADDR_WIDTH+1  count of acked words in the current/last load
- `s_data_i`  in  8  stream byte
- `s_valid_i`  in  1  byte valid
- `s_last_i`  in  1  byte is the final byte of the image
- `s_ready_o`  out  1  byte accepted when `s_valid_i & s_ready_o`
- `wb_adr_o`  out  ADDR_WIDTH  word address
- `wb_dat_o`  out  32  write data
- `wb_sel_o`  out  4  byte select
- `wb_we_o`  out  1  write enable; equals `wb_cyc_o`
- `wb_cyc_o`  out  1  cycle
- `wb_stb_o`  out  1  strobe
- `wb_stall_i`  in  1  slave stall
- `wb_ack_i`  in  1  slave ack
- `wb_err_i`  in  1  slave error

## Operation
States: IDLE, COLLECT, WRITE, WAIT_ACK.
- **IDLE:** `s_ready_o`=0, `cyc`=`stb`=0.
  - `start_i` → COLLECT.
  - Load address with `base_adr_i`; clear `words_o`, `error_o`, byte index and data/sel registers.
- **COLLECT:** `s_ready_o`=1.
  - Byte k (k=0..3) goes to bits [8k+7:8k] and sets `sel[k]`.
  - Go to WRITE on the 4th byte or on a byte with `s_last_i`. The last-byte flag is latched.
  - Unfilled bytes are 0 with their sel bits clear. Every load writes at least one word.
- **WRITE:** `cyc`=`stb`=`we`=1, `s_ready_o`=0.
  - `wb_stall_i`=0 → WAIT_ACK.
  - `adr`/`dat`/`sel` stay stable while stalled.
- **WAIT_ACK:** `cyc`=1, `stb`=0.
- **Completion:** `wb_ack_i` in WRITE or WAIT_ACK completes the write. Ack in WRITE is needed because a classic slave behind a stall adapter drops stall on the ack cycle.
  - On completion: `words_o`+1, address +1 modulo 2^ADDR_WIDTH (wrap-around, no error), byte index and data/sel registers cleared.
  - If the latched last flag is set → `done_o` pulse, IDLE; otherwise → COLLECT.
- **Abort:** `wb_err_i` in WRITE/WAIT_ACK, or timeout counter reaching TIMEOUT.
  - Result: `error_o`=1, `done_o` pulse, drop `cyc` next cycle, IDLE.
  - `words_o` excludes the failed word. Remaining stream bytes are not consumed.
- **Timeout counter:** width $clog2(TIMEOUT+1). Cleared on entry to WRITE; increments each cycle in WRITE/WAIT_ACK without ack/err.
- **Simultaneous events:** ack and err on the same cycle → err wins. `start_i` while busy → ignored, no side effects.

## Timing
- Async reset values: state IDLE; all outputs 0; `words_o`=0. Reset asserted mid-load drops `cyc`/`stb` immediately; no done pulse.
- Registered outputs throughout; `s_ready_o` is decoded from state only, with no combinational path from the Wishbone inputs.
- Per full word, with a zero-stall slave acking 1 cycle after stb: 4 byte cycles, 1 stb cycle, 1 ack cycle → next byte accepted 1 cycle after ack. That is 6 cycles/word minimum.
- `done_o` is asserted the cycle after the final ack or abort; `busy_o` drops the cycle after that.
- Start to first `s_ready_o`=1: 1 cycle.

## Test plan
- **Full words:** base 0x010, bytes 11 22 33 44 55 66 77 88 (last on 88).
  - Writes: adr 0x010 dat 0x44332211 sel 0xF; adr 0x011 dat 0x88776655 sel 0xF.
  - Then one `done_o`, `words_o`=2, `error_o`=0.
- **Partial word:** 5 bytes 01..05.
  - Second write adr base+1, dat 0x00000005, sel 0x1; `words_o`=2.
- **Stall:** slave holds stall 3 cycles, then stall-low with ack on the same cycle (classic adapter).
  - `stb` held 4 cycles with `adr`/`dat` stable; exactly one write counted; next byte accepted 1 cycle later.
- **Error and wrap:**
  - `wb_err_i` on the 2nd word → `error_o`=1, `done_o` pulse, `words_o`=1, `cyc` low next cycle, `s_ready_o`=0.
  - Base 0x3FFF with 8 bytes → writes at 0x3FFF then 0x0000.
- **Timeout:** TIMEOUT=8, slave never acks.
  - `cyc` drops after 8 cycles in WRITE/WAIT_ACK; `error_o`=1; `words_o`=0.
  - Next `start_i` clears `error_o` and a normal load then succeeds.
- **Start/reset robustness:**
  - `start_i` pulsed mid-load → no effect on address or count.
  - `rst_n` low mid-WRITE → `cyc`/`stb`/`busy_o` 0 immediately; no `done_o` pulse.
